// File: rtl/fault_mem_cfg_if.sv
// Access and fault-configuration bundle for fault_mem_cfg.
// master: drives configuration, access command and write data; receives rdata/fault_hit.
// slave : the memory model; receives configuration and accesses, returns rdata/fault_hit.
interface fault_mem_cfg_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned BIT_IDX_W  = 3
);
   logic                  cfg_load;
   logic [2:0]            cfg_type;
   logic [ADDR_WIDTH-1:0] cfg_vaddr;
   logic [BIT_IDX_W-1:0]  cfg_vbit;
   logic [ADDR_WIDTH-1:0] cfg_aaddr;
   logic [BIT_IDX_W-1:0]  cfg_abit;
   logic                  write_read;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  fault_hit;

   modport master (
      output cfg_load, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
      output write_read, address, wdata,
      input  rdata, fault_hit
   );

   modport slave (
      input  cfg_load, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
      input  write_read, address, wdata,
      output rdata, fault_hit
   );
endinterface

// File: rtl/fault_mem_cfg.sv
// Single-port behavioural memory with one run-time programmable fault
// (SA0/SA1, TF-up/down, CFin-up, CFid-up, SOF) for exercising MBIST March runs.
// Ports: clk, rst (async, active-high), bus (fault_mem_cfg_if.slave) carrying
// cfg_* fault configuration, write_read/address/wdata access, rdata and the
// one-cycle fault_hit pulse. Read latency is two edges; a write or read is
// accepted every cycle.
module fault_mem_cfg #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned BIT_IDX_W  = 3
) (
   input  logic            clk,
   input  logic            rst,
   fault_mem_cfg_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_SA0  = 3'd1;
   localparam logic [2:0] T_SA1  = 3'd2;
   localparam logic [2:0] T_TFU  = 3'd3;
   localparam logic [2:0] T_TFD  = 3'd4;
   localparam logic [2:0] T_CFIN = 3'd5;
   localparam logic [2:0] T_CFID = 3'd6;
   localparam logic [2:0] T_SOF  = 3'd7;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [2:0]            cfg_type_q;
   logic [ADDR_WIDTH-1:0] cfg_vaddr_q;
   logic [BIT_IDX_W-1:0]  cfg_vbit_q;
   logic [ADDR_WIDTH-1:0] cfg_aaddr_q;
   logic [BIT_IDX_W-1:0]  cfg_abit_q;

   logic                  s1_write;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_wdata;
   logic [DATA_WIDTH-1:0] rd_reg;

   logic [2:0]            eff_type_c;
   logic [DATA_WIDTH-1:0] vmask_c;
   logic [DATA_WIDTH-1:0] amask_c;
   logic [DATA_WIDTH-1:0] fmask_c;
   logic [DATA_WIDTH-1:0] old_word_c;
   logic [DATA_WIDTH-1:0] vic_word_c;
   logic [DATA_WIDTH-1:0] wr_word_c;
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic [DATA_WIDTH-1:0] vic_new_c;
   logic                  vic_we_c;
   logic                  rd_upd_c;
   logic                  hit_c;
   logic                  is_v_c;
   logic                  is_a_c;
   logic                  cf_trig_c;

   // Effective fault type: out-of-range bits or self-coupling disable the fault
   always_comb begin
      eff_type_c = cfg_type_q;
      if ((32'(cfg_vbit_q) >= DATA_WIDTH) || (32'(cfg_abit_q) >= DATA_WIDTH))
         eff_type_c = T_NONE;
      if (((cfg_type_q == T_CFIN) || (cfg_type_q == T_CFID)) && (cfg_aaddr_q == cfg_vaddr_q))
         eff_type_c = T_NONE;
   end

   // Commit-edge fault evaluation for the stage-1 operation
   always_comb begin
      vmask_c    = DATA_WIDTH'(1) << cfg_vbit_q;
      amask_c    = DATA_WIDTH'(1) << cfg_abit_q;
      fmask_c    = (eff_type_c == T_SA1) ? vmask_c : '0;
      old_word_c = mem[s1_addr];
      vic_word_c = mem[cfg_vaddr_q];
      is_v_c     = (s1_addr == cfg_vaddr_q);
      is_a_c     = (s1_addr == cfg_aaddr_q);
      wr_word_c  = s1_wdata;
      rd_word_c  = old_word_c;
      vic_new_c  = vic_word_c;
      vic_we_c   = 1'b0;
      rd_upd_c   = !s1_write;
      hit_c      = 1'b0;
      // aggressor rising transition on a write to the aggressor word
      cf_trig_c  = s1_write && is_a_c && ((old_word_c & amask_c) == '0)
                   && ((s1_wdata & amask_c) != '0);
      case (eff_type_c)
         T_SA0, T_SA1: begin
            if (is_v_c && s1_write) begin
               wr_word_c = (s1_wdata & ~vmask_c) | fmask_c;
               hit_c     = ((s1_wdata & vmask_c) != fmask_c);
            end else if (is_v_c) begin
               rd_word_c = (old_word_c & ~vmask_c) | fmask_c;
               hit_c     = ((old_word_c & vmask_c) != fmask_c);
            end
         end
         T_TFU: begin
            if (s1_write && is_v_c && ((old_word_c & vmask_c) == '0)
                && ((s1_wdata & vmask_c) != '0)) begin
               wr_word_c = s1_wdata & ~vmask_c;
               hit_c     = 1'b1;
            end
         end
         T_TFD: begin
            if (s1_write && is_v_c && ((old_word_c & vmask_c) != '0)
                && ((s1_wdata & vmask_c) == '0)) begin
               wr_word_c = s1_wdata | vmask_c;
               hit_c     = 1'b1;
            end
         end
         T_CFIN: begin
            if (cf_trig_c) begin
               vic_we_c  = 1'b1;
               vic_new_c = vic_word_c ^ vmask_c;
               hit_c     = 1'b1;
            end
         end
         T_CFID: begin
            if (cf_trig_c) begin
               vic_we_c  = 1'b1;
               vic_new_c = vic_word_c | vmask_c;
               hit_c     = ((vic_word_c & vmask_c) == '0);
            end
         end
         T_SOF: begin
            // stuck-open cell: the read register keeps the previous result
            if (!s1_write && is_v_c) begin
               rd_upd_c = 1'b0;
               hit_c    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Array storage; not reset. Victim and aggressor never share an address.
   always_ff @(posedge clk) begin
      if (s1_write)
         mem[s1_addr] <= wr_word_c;
      if (vic_we_c)
         mem[cfg_vaddr_q] <= vic_new_c;
   end

   // Config capture, stage-1 sampling, read register and output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_type_q    <= T_NONE;
         cfg_vaddr_q   <= '0;
         cfg_vbit_q    <= '0;
         cfg_aaddr_q   <= '0;
         cfg_abit_q    <= '0;
         s1_write      <= 1'b0;
         s1_addr       <= '0;
         s1_wdata      <= '0;
         rd_reg        <= '0;
         bus.rdata     <= '0;
         bus.fault_hit <= 1'b0;
      end else begin
         if (bus.cfg_load) begin
            cfg_type_q  <= bus.cfg_type;
            cfg_vaddr_q <= bus.cfg_vaddr;
            cfg_vbit_q  <= bus.cfg_vbit;
            cfg_aaddr_q <= bus.cfg_aaddr;
            cfg_abit_q  <= bus.cfg_abit;
         end
         s1_write <= bus.write_read;
         s1_addr  <= bus.address;
         s1_wdata <= bus.wdata;
         if (rd_upd_c)
            rd_reg <= rd_word_c;
         bus.rdata     <= rd_reg;
         bus.fault_hit <= hit_c;
      end
   end
endmodule

// File: tb/tb_fault_mem_cfg.sv
// Scoreboard bench for fault_mem_cfg: directed fault scenarios plus randomized
// accesses/configurations, checked against a word-level reference model.
module tb_fault_mem_cfg;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int BW = 3;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   fault_mem_cfg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_IDX_W(BW)) bus ();

   fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_IDX_W(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic [DW-1:0] val;
      bit           chk;
   } exp_t;

   exp_t hit_q[$];
   exp_t rd_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [DW-1:0] m [DEPTH];
   bit            mk [DEPTH];
   logic [DW-1:0] last_rd;
   bit            last_known;
   int mc_type, mc_va, mc_vb, mc_aa, mc_ab;
   bit cfg_pend = 0;
   int pc_type, pc_va, pc_vb, pc_aa, pc_ab;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
      end
   endtask

   function automatic int eff_type();
      if (mc_vb >= DW || mc_ab >= DW) return 0;
      if ((mc_type == 5 || mc_type == 6) && mc_aa == mc_va) return 0;
      return mc_type;
   endfunction

   // Apply one access to the model; returns whether the fault changed anything
   task automatic model_step(input bit wr, input int a, input logic [DW-1:0] d, output bit hit);
      int t;
      logic [DW-1:0] w;
      bit trig;
      t    = eff_type();
      hit  = 0;
      trig = 0;
      if (wr) begin
         w = d;
         if (a == mc_va) begin
            if (t == 1 || t == 2) begin
               if (w[mc_vb] != (t == 2)) hit = 1;
               w[mc_vb] = (t == 2);
            end
            if (t == 3 && m[a][mc_vb] == 1'b0 && d[mc_vb] == 1'b1) begin
               w[mc_vb] = 1'b0;
               hit = 1;
            end
            if (t == 4 && m[a][mc_vb] == 1'b1 && d[mc_vb] == 1'b0) begin
               w[mc_vb] = 1'b1;
               hit = 1;
            end
         end
         if ((t == 5 || t == 6) && a == mc_aa && m[a][mc_ab] == 1'b0 && d[mc_ab] == 1'b1)
            trig = 1;
         m[a]  = w;
         mk[a] = 1;
         if (trig) begin
            if (t == 5) begin
               m[mc_va][mc_vb] = ~m[mc_va][mc_vb];
               hit = 1;
            end else begin
               if (m[mc_va][mc_vb] == 1'b0) hit = 1;
               m[mc_va][mc_vb] = 1'b1;
            end
         end
      end else begin
         w = m[a];
         if ((t == 1 || t == 2) && a == mc_va) begin
            if (w[mc_vb] != (t == 2)) hit = 1;
            w[mc_vb] = (t == 2);
         end
         if (t == 7 && a == mc_va) hit = 1;
         else begin
            last_rd    = w;
            last_known = mk[a];
         end
      end
   endtask

   task automatic push_exp(input int off, input bit h, input int exp_hit, input int exp_rd);
      exp_t e;
      e.due = cyc + off;
      e.val = (exp_hit >= 0) ? DW'(exp_hit) : DW'(h);
      e.chk = 1;
      hit_q.push_back(e);
      e.due = cyc + off + 1;
      e.val = (exp_rd >= 0) ? DW'(exp_rd) : last_rd;
      e.chk = (exp_rd >= 0) ? 1'b1 : last_known;
      rd_q.push_back(e);
   endtask

   task automatic set_cfg(input int t, input int va, input int vb, input int aa, input int ab);
      bus.cfg_type  = 3'(t);
      bus.cfg_vaddr = AW'(va);
      bus.cfg_vbit  = BW'(vb);
      bus.cfg_aaddr = AW'(aa);
      bus.cfg_abit  = BW'(ab);
      pc_type = t; pc_va = va; pc_vb = vb; pc_aa = aa; pc_ab = ab;
      cfg_pend = 1;
   endtask

   // Drive one access at the current negedge, then advance to the next negedge
   task automatic op(input bit wr, input int a, input logic [DW-1:0] d,
                     input int exp_hit = -1, input int exp_rd = -1, input bit apply = 1);
      bit h;
      bus.write_read = wr;
      bus.address    = AW'(a);
      bus.wdata      = d;
      bus.cfg_load   = cfg_pend;
      if (cfg_pend) begin
         mc_type = pc_type; mc_va = pc_va; mc_vb = pc_vb; mc_aa = pc_aa; mc_ab = pc_ab;
         cfg_pend = 0;
      end
      if (apply) begin
         model_step(wr, a, d, h);
         push_exp(2, h, exp_hit, exp_rd);
      end
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge where rst is released
   task automatic do_reset();
      bit h;
      rst = 1'b1;
      bus.cfg_load = 1'b0;
      cfg_pend = 0;
      hit_q.delete();
      rd_q.delete();
      repeat (3) @(negedge clk);
      check("reset_rdata", bus.rdata, '0);
      check("reset_fault_hit", DW'(bus.fault_hit), '0);
      rst = 1'b0;
      mc_type = 0; mc_va = 0; mc_vb = 0; mc_aa = 0; mc_ab = 0;
      // cleared stage 1 is a read of address 0 that commits on the next edge
      last_rd = '0;
      last_known = 1;
      model_step(1'b0, 0, '0, h);
      push_exp(1, h, -1, -1);
   endtask

   // Monitor: compare outputs whenever a scheduled response is due
   always @(negedge clk) begin
      if (!rst) begin
         while (hit_q.size() > 0 && hit_q[0].due <= cyc) begin
            exp_t e;
            e = hit_q.pop_front();
            if (e.chk) check("fault_hit", DW'(bus.fault_hit), e.val);
         end
         while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            exp_t e;
            e = rd_q.pop_front();
            if (e.chk) check("rdata", bus.rdata, e.val);
         end
      end
   end

   initial begin
      bus.cfg_load = 0; bus.cfg_type = 0; bus.cfg_vaddr = 0; bus.cfg_vbit = 0;
      bus.cfg_aaddr = 0; bus.cfg_abit = 0;
      bus.write_read = 0; bus.address = 0; bus.wdata = 0;
      for (int i = 0; i < DEPTH; i++) mk[i] = 0;
      @(negedge clk);
      do_reset();

      for (int i = 0; i < DEPTH; i++) op(1'b1, i, DW'($urandom));

      // plain write / read
      op(1'b1, 3, 8'hA5, 0);
      op(1'b0, 3, 8'h00, 0, 8'hA5);

      // stuck-at-1
      set_cfg(2, 2, 0, 0, 0);
      op(1'b1, 2, 8'h00, 1);
      op(1'b0, 2, 8'h00, 0, 8'h01);
      op(1'b1, 5, 8'h00, 0);
      op(1'b0, 5, 8'h00, 0, 8'h00);

      // transition fault, rising
      set_cfg(3, 4, 1, 0, 0);
      op(1'b1, 4, 8'h00, 0);
      op(1'b1, 4, 8'hFF, 1);
      op(1'b0, 4, 8'h00, 0, 8'hFD);
      op(1'b1, 4, 8'h00, 0);
      op(1'b0, 4, 8'h00, 0, 8'h00);

      // inversion coupling
      set_cfg(5, 9, 3, 1, 7);
      op(1'b1, 9, 8'h00, 0);
      op(1'b1, 1, 8'h00, 0);
      op(1'b1, 1, 8'h80, 1);
      op(1'b0, 9, 8'h00, 0, 8'h08);
      op(1'b1, 1, 8'h80, 0);
      op(1'b0, 9, 8'h00, 0, 8'h08);

      // stuck-open
      set_cfg(7, 6, 0, 0, 0);
      op(1'b1, 0, 8'h11, 0);
      op(1'b1, 6, 8'h22, 0);
      op(1'b0, 0, 8'h00, 0, 8'h11);
      op(1'b0, 6, 8'h00, 1, 8'h11);

      // reset with a write still in stage 1
      op(1'b1, 7, 8'h5C, 0);
      op(1'b1, 7, 8'hEE, -1, -1, 1'b0);
      do_reset();
      op(1'b0, 7, 8'h00, 0, 8'h5C);
      op(1'b0, 6, 8'h00, 0, 8'h22);

      // randomized accesses over a small address window to hit faults often
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0)
            set_cfg($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, DW - 1),
                    $urandom_range(0, 3), $urandom_range(0, DW - 1));
         op(1'(($urandom_range(0, 1))), $urandom_range(0, 3), DW'($urandom));
      end

      repeat (4) @(negedge clk);
      check("drain_queues", DW'(hit_q.size() + rd_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
